bno085_spi_arbiter: RTL and testbench
=====================================

Name: bno085_spi_arbiter

Overview:
Shares the single spi_master (shared sclk/mosi) between two bno085_controller instances, so both hand sensors run without multiple drivers on the bus. Each controller's own cs_n acts as its bus request. The arbiter grants ownership round-robin and routes the owner's byte handshake to the master. It drives the physical cs_n1/cs_n2 pins and evicts an owner that holds the bus too long. It sits between the two controllers and spi_master_inst1 in drum_trigger_top.

Parameters:
CS_GAP, 4, clk cycles both chip selects stay high between ownerships (minimum 1).
MAX_HOLD, 3_000_000, maximum cycles in one grant before forced eviction (1 s at 3 MHz).
HOLD_W, 24, width of the hold counter; must satisfy MAX_HOLD < 2^HOLD_W.

Ports:
clk  in  1  system clock (3 MHz HSOSC)
fpga_rst_n  in  1  asynchronous active-low reset
rq_cs_n[1:0]  in  2  per-controller cs_n; low = bus request
rq_start[1:0]  in  2  per-controller start pulse
rq_tx_valid[1:0]  in  2  per-controller tx_valid
rq0_tx_data, rq1_tx_data  in  8 each  per-controller tx byte
rq_tx_ready[1:0]  out  2  tx_ready to each controller
rq_rx_valid[1:0]  out  2  rx_valid to each controller
rq_rx_data  out  8  rx byte, broadcast; qualified by rq_rx_valid
rq_busy[1:0]  out  2  busy to each controller
m_start, m_tx_valid  out  1 each  to spi_master
m_tx_data  out  8  to spi_master
m_tx_ready, m_rx_valid, m_busy  in  1 each  from spi_master
m_rx_data  in  8  from spi_master
cs_n_pin[1:0]  out  2  physical chip selects (cs_n1, cs_n2)
owner  out  2  one-hot current owner; 00 = none
timeout_err  out  1  sticky eviction flag

Behaviour:
Reset: clock clk; reset fpga_rst_n is asynchronous and active-low. On reset:
- state IDLE, cs_n_pin=11, owner=00, timeout_err=0
- last_owner=1, so requester 0 wins the first tie
- pending starts, lockouts and counters all cleared
- rq_busy=11 while in reset; all other outputs 0

FSM states: IDLE, GRANT0, GRANT1, GAP.
- IDLE: a requester is eligible when rq_cs_n[i]=0 and lockout[i]=0.
  - One eligible requester: go to GRANTi next cycle.
  - Both eligible: grant the one that is not last_owner.
  - None eligible: stay in IDLE.
- GRANTi: cs_n_pin[i]=rq_cs_n[i]; the other pin is held at 1; owner[i]=1.
  - Pin CS goes low 1 cycle after the request is sampled.
  - m_start/m_tx_valid/m_tx_data come from requester i.
  - rq_tx_ready[i]=m_tx_ready; rq_busy[i]=m_busy; rq_rx_valid[i]=m_rx_valid; no added latency (combinational mux).
- GRANTi exit:
  - Normal release: rq_cs_n[i]=1 and m_busy=0 → GAP, last_owner=i.
  - Eviction: hold counter reaches MAX_HOLD-1 → GAP, set timeout_err, set lockout[i].
  - If m_busy=1 at eviction, wait in GRANTi with the pin forced high until m_busy=0.
- GAP: both pins high; count CS_GAP cycles, then return to IDLE.
- Non-owner j, in every state:
  - rq_tx_ready[j]=0, rq_rx_valid[j]=0, rq_busy[j]=1.
  - An rq_start[j] pulse sets pending_start[j].
  - On entering GRANTj, m_start is driven for 1 cycle if pending_start[j]=1, then pending_start[j] is cleared.
  - A start pulse from the owner passes straight through.
- lockout[i] clears when rq_cs_n[i]=1 is sampled, so the controller must end its transaction first.
- Simultaneous events:
  - A release and a new request from the other side in the same cycle still goes through GAP first.
  - A request arriving during GAP is served from IDLE.
- The hold counter saturates and resets on every grant entry.
- timeout_err clears only on reset.

Decomposition:
- Package bno085_pkg: arb_state_t enum (IDLE/GRANT0/GRANT1/GAP); localparams for the 3 MHz clock rate and default hold/gap values. Shared with bno085_controller.
- Sub-module rr_grant2: pure 2-way round-robin picker (eligible[1:0], last_owner → grant_idx, grant_valid). Registers stay in the parent.

Test Plan:
- Reset mid-GRANT0 with pin low → cs_n_pin=11, owner=00 same cycle (async); after release, first tie goes to requester 0.
- Only rq_cs_n[0] falls at cycle 10 → owner=01 and cs_n_pin=10 at cycle 11. Byte 0xA5 echoed by the master model → rq_rx_valid[0]=1, rq_rx_data=0xA5, rq_rx_valid[1] stays 0.
- Both rq_cs_n fall in the same cycle from IDLE, last_owner=1 → GRANT0. After release, exactly CS_GAP=4 cycles with cs_n_pin=11, then GRANT1.
- Requester 1 pulses rq_start while 0 owns → master sees no start. On GRANT1 entry, m_start=1 for exactly 1 cycle; rq_busy[1]=1 throughout the wait.
- Requester 0 holds cs_n low with MAX_HOLD=100 → pin released at cycle 100 after m_busy=0, timeout_err=1. Requester 0 is not regranted until it raises cs_n; requester 1 is granted meanwhile.
- Release requested while m_busy=1 → grant held until m_busy falls, then GAP; no truncated byte on miso routing.

Source files
------------

// File: rtl/bno085_pkg.sv
// Shared definitions for the BNO085 sensor path: clock rate, arbiter defaults
// and the arbiter state encoding.
package bno085_pkg;

    localparam int CLK_HZ           = 3_000_000;
    localparam int DEFAULT_CS_GAP   = 4;
    localparam int DEFAULT_MAX_HOLD = CLK_HZ;
    localparam int DEFAULT_HOLD_W   = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin picker: on a tie the requester that did not own last wins.
module rr_grant2 (
    input  logic [1:0] eligible,
    input  logic       last_owner,
    output logic       grant_idx,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |eligible;
        case (eligible)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_owner;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bno085_spi_arbiter.sv
// Shares one spi_master between two bno085_controller instances; each
// controller's cs_n is its bus request, ownership is granted round-robin.
module bno085_spi_arbiter
    import bno085_pkg::*;
#(
    parameter int CS_GAP   = DEFAULT_CS_GAP,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int HOLD_W   = DEFAULT_HOLD_W
) (
    input  logic       clk,
    input  logic       fpga_rst_n,
    input  logic [1:0] rq_cs_n,
    input  logic [1:0] rq_start,
    input  logic [1:0] rq_tx_valid,
    input  logic [7:0] rq0_tx_data,
    input  logic [7:0] rq1_tx_data,
    output logic [1:0] rq_tx_ready,
    output logic [1:0] rq_rx_valid,
    output logic [7:0] rq_rx_data,
    output logic [1:0] rq_busy,
    output logic       m_start,
    output logic       m_tx_valid,
    output logic [7:0] m_tx_data,
    input  logic       m_tx_ready,
    input  logic       m_rx_valid,
    input  logic       m_busy,
    input  logic [7:0] m_rx_data,
    output logic [1:0] cs_n_pin,
    output logic [1:0] owner,
    output logic       timeout_err
);

    localparam int                GAP_W     = $clog2(CS_GAP + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_GAP - 1);

    arb_state_t        state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic [1:0]        pending_start_q, pending_start_d;
    logic [1:0]        lockout_q, lockout_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              evict_q, evict_d;
    logic              timeout_err_q, timeout_err_d;

    logic [1:0] eligible;
    logic [1:0] lockout_set;
    logic       pick_idx, pick_valid;
    logic       own_valid, own_idx;

    assign eligible  = ~rq_cs_n & ~lockout_q;
    assign own_valid = (state_q == GRANT0) || (state_q == GRANT1);
    assign own_idx   = (state_q == GRANT1);

    rr_grant2 u_pick (
        .eligible    (eligible),
        .last_owner  (last_owner_q),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d         = state_q;
        last_owner_d    = last_owner_q;
        hold_cnt_d      = '0;
        gap_cnt_d       = '0;
        evict_d         = evict_q;
        timeout_err_d   = timeout_err_q;
        lockout_set     = 2'b00;
        pending_start_d = pending_start_q | (rq_start & ~owner);

        case (state_q)
            IDLE: begin
                if (pick_valid) state_d = pick_idx ? GRANT1 : GRANT0;
            end
            GRANT0, GRANT1: begin
                hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
                pending_start_d[own_idx] = 1'b0;
                if (evict_q) begin
                    // Evicted owner keeps the routing until its byte finishes.
                    if (!m_busy) begin
                        state_d = GAP;
                        evict_d = 1'b0;
                    end
                end else if (rq_cs_n[own_idx] && !m_busy) begin
                    state_d      = GAP;
                    last_owner_d = own_idx;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    timeout_err_d        = 1'b1;
                    lockout_set[own_idx] = 1'b1;
                    if (m_busy) evict_d = 1'b1;
                    else        state_d = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A locked-out requester must raise cs_n before it can compete again.
        lockout_d = (lockout_q & ~rq_cs_n) | lockout_set;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state_q         <= IDLE;
            last_owner_q    <= 1'b1;
            pending_start_q <= 2'b00;
            lockout_q       <= 2'b00;
            hold_cnt_q      <= '0;
            gap_cnt_q       <= '0;
            evict_q         <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_owner_q    <= last_owner_d;
            pending_start_q <= pending_start_d;
            lockout_q       <= lockout_d;
            hold_cnt_q      <= hold_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            evict_q         <= evict_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    always_comb begin
        owner       = own_valid ? (own_idx ? 2'b10 : 2'b01) : 2'b00;
        cs_n_pin    = 2'b11;
        rq_tx_ready = 2'b00;
        rq_rx_valid = 2'b00;
        rq_busy     = 2'b11;
        rq_rx_data  = 8'h00;
        m_start     = 1'b0;
        m_tx_valid  = 1'b0;
        m_tx_data   = 8'h00;

        if (own_valid) begin
            rq_tx_ready[own_idx] = m_tx_ready;
            rq_rx_valid[own_idx] = m_rx_valid;
            rq_busy[own_idx]     = m_busy;
            rq_rx_data           = m_rx_data;
            if (!evict_q) begin
                cs_n_pin[own_idx] = rq_cs_n[own_idx];
                // A start deferred while another side owned the bus fires on the first grant cycle.
                m_start    = rq_start[own_idx] | ((hold_cnt_q == '0) & pending_start_q[own_idx]);
                m_tx_valid = rq_tx_valid[own_idx];
                m_tx_data  = own_idx ? rq1_tx_data : rq0_tx_data;
            end
        end
    end

    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bno085_spi_arbiter.sv
// Directed bench for bno085_spi_arbiter: a vector table for grant/tie/gap
// routing, then hand-written eviction, lockout and async-reset sequences.
module tb_bno085_spi_arbiter;

    logic       clk = 1'b0;
    logic       fpga_rst_n;
    logic [1:0] rq_cs_n, rq_start, rq_tx_valid;
    logic [7:0] rq0_tx_data, rq1_tx_data;
    logic [1:0] rq_tx_ready, rq_rx_valid, rq_busy;
    logic [7:0] rq_rx_data;
    logic       m_start, m_tx_valid;
    logic [7:0] m_tx_data;
    logic       m_tx_ready, m_rx_valid, m_busy;
    logic [7:0] m_rx_data;
    logic [1:0] cs_n_pin, owner;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    bno085_spi_arbiter #(.CS_GAP(4), .MAX_HOLD(100), .HOLD_W(24)) dut (
        .clk         (clk),
        .fpga_rst_n  (fpga_rst_n),
        .rq_cs_n     (rq_cs_n),
        .rq_start    (rq_start),
        .rq_tx_valid (rq_tx_valid),
        .rq0_tx_data (rq0_tx_data),
        .rq1_tx_data (rq1_tx_data),
        .rq_tx_ready (rq_tx_ready),
        .rq_rx_valid (rq_rx_valid),
        .rq_rx_data  (rq_rx_data),
        .rq_busy     (rq_busy),
        .m_start     (m_start),
        .m_tx_valid  (m_tx_valid),
        .m_tx_data   (m_tx_data),
        .m_tx_ready  (m_tx_ready),
        .m_rx_valid  (m_rx_valid),
        .m_busy      (m_busy),
        .m_rx_data   (m_rx_data),
        .cs_n_pin    (cs_n_pin),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cs_n;
        logic [1:0]  start;
        logic [1:0]  txv;
        logic        mrdy;
        logic        mrxv;
        logic        mbusy;
        logic [27:0] exp_out;
    } vec_t;

    vec_t vecs[16];

    // exp_out = {cs_n_pin, owner, m_start, m_tx_valid, m_tx_data, rq_busy, rq_rx_valid, rq_rx_data, rq_tx_ready}
    function automatic vec_t mk(input logic [1:0] cs_n, input logic [1:0] start, input logic [1:0] txv,
                                input logic mrdy, input logic mrxv, input logic mbusy,
                                input logic [1:0] pin, input logic [1:0] own, input logic mst,
                                input logic mtxv, input logic [7:0] mtxd, input logic [1:0] busy,
                                input logic [1:0] rxv, input logic [7:0] rxd, input logic [1:0] txr);
        vec_t v;
        v.cs_n    = cs_n;
        v.start   = start;
        v.txv     = txv;
        v.mrdy    = mrdy;
        v.mrxv    = mrxv;
        v.mbusy   = mbusy;
        v.exp_out = {pin, own, mst, mtxv, mtxd, busy, rxv, rxd, txr};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int limit);
        for (int w = 0; w < limit; w++) begin
            @(negedge clk);
            #1;
            if (owner != 2'b00) break;
        end
    endtask

    task automatic idle_inputs();
        rq_cs_n     = 2'b11;
        rq_start    = 2'b00;
        rq_tx_valid = 2'b00;
        m_tx_ready  = 1'b0;
        m_rx_valid  = 1'b0;
        m_busy      = 1'b0;
    endtask

    initial begin
        int seen;

        vecs[0]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b11, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 8'h00, 2'b00);
        vecs[1]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b11, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 8'h00, 2'b00);
        vecs[2]  = mk(2'b00, 2'b01, 2'b01, 1, 0, 0, 2'b10, 2'b01, 1, 1, 8'h3C, 2'b10, 2'b00, 8'hA5, 2'b01);
        vecs[3]  = mk(2'b00, 2'b10, 2'b00, 0, 0, 1, 2'b10, 2'b01, 0, 0, 8'h3C, 2'b11, 2'b00, 8'hA5, 2'b00);
        vecs[4]  = mk(2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b10, 2'b01, 0, 0, 8'h3C, 2'b10, 2'b01, 8'hA5, 2'b01);
        vecs[5]  = mk(2'b01, 2'b00, 2'b00, 0, 0, 1, 2'b11, 2'b01, 0, 0, 8'h3C, 2'b11, 2'b00, 8'hA5, 2'b00);
        vecs[6]  = mk(2'b01, 2'b00, 2'b00, 0, 1, 0, 2'b11, 2'b01, 0, 0, 8'h3C, 2'b10, 2'b01, 8'hA5, 2'b00);
        for (int i = 7; i <= 11; i++)
            vecs[i] = mk(2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b11, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 8'h00, 2'b00);
        vecs[12] = mk(2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b10, 1, 0, 8'hC3, 2'b01, 2'b00, 8'hA5, 2'b00);
        vecs[13] = mk(2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b10, 0, 0, 8'hC3, 2'b01, 2'b00, 8'hA5, 2'b00);
        vecs[14] = mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b11, 2'b10, 0, 0, 8'hC3, 2'b01, 2'b00, 8'hA5, 2'b00);
        vecs[15] = mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b11, 2'b00, 0, 0, 8'h00, 2'b11, 2'b00, 8'h00, 2'b00);

        idle_inputs();
        rq0_tx_data = 8'h3C;
        rq1_tx_data = 8'hC3;
        m_rx_data   = 8'hA5;
        fpga_rst_n  = 1'b0;
        #23;
        check("rst_pin",   32'(cs_n_pin), 32'h3);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy",  32'(rq_busy), 32'h3);
        check("rst_misc",  32'({m_start, m_tx_valid, m_tx_data, rq_tx_ready, rq_rx_valid, rq_rx_data, timeout_err}), 32'h0);
        @(negedge clk);
        fpga_rst_n = 1'b1;

        // Tie from IDLE, byte echo, release under busy, gap length, deferred start.
        foreach (vecs[i]) begin
            @(negedge clk);
            rq_cs_n     = vecs[i].cs_n;
            rq_start    = vecs[i].start;
            rq_tx_valid = vecs[i].txv;
            m_tx_ready  = vecs[i].mrdy;
            m_rx_valid  = vecs[i].mrxv;
            m_busy      = vecs[i].mbusy;
            #1;
            check($sformatf("vec%0d", i),
                  32'({cs_n_pin, owner, m_start, m_tx_valid, m_tx_data, rq_busy, rq_rx_valid, rq_rx_data, rq_tx_ready}),
                  32'(vecs[i].exp_out));
        end

        @(negedge clk);
        idle_inputs();
        repeat (8) @(negedge clk);

        // Eviction: requester 0 holds cs_n low; master busy across the eviction point.
        rq_cs_n = 2'b10;
        wait_grant(5);
        check("evict_grant", 32'(owner), 32'h1);
        for (int g = 1; g <= 106; g++) begin
            @(negedge clk);
            m_busy = (g >= 95 && g <= 104);
            if (g == 50) rq_cs_n[1] = 1'b0;
            #1;
            if (g == 99) begin
                check("evict_pin_before", 32'(cs_n_pin), 32'h2);
                check("evict_err_before", 32'(timeout_err), 32'h0);
            end
            if (g == 100) begin
                check("evict_pin_forced", 32'(cs_n_pin), 32'h3);
                check("evict_owner_wait", 32'(owner), 32'h1);
                check("evict_err_set", 32'(timeout_err), 32'h1);
            end
            if (g == 105) check("evict_owner_last", 32'(owner), 32'h1);
            if (g == 106) check("evict_owner_gone", 32'(owner), 32'h0);
        end

        // Requester 1 is served while the evicted requester 0 stays locked out.
        wait_grant(10);
        check("lock_grant1", 32'(owner), 32'h2);
        check("lock_pin1", 32'(cs_n_pin), 32'h1);
        @(negedge clk);
        rq_cs_n = 2'b10;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (owner == 2'b01) seen++;
        end
        check("lock_no_regrant", 32'(seen), 32'h0);
        @(negedge clk);
        rq_cs_n = 2'b11;
        @(negedge clk);
        rq_cs_n = 2'b10;
        wait_grant(10);
        check("lock_cleared", 32'(owner), 32'h1);
        check("err_sticky", 32'(timeout_err), 32'h1);

        // Normal release by 0 makes last_owner=0; re-grant 0, then reset mid-grant.
        @(negedge clk);
        rq_cs_n = 2'b11;
        repeat (8) @(negedge clk);
        rq_cs_n = 2'b10;
        wait_grant(5);
        check("pre_rst_pin", 32'({owner, cs_n_pin}), 32'h6);
        @(posedge clk);
        #2;
        fpga_rst_n = 1'b0;
        #1;
        check("async_rst_pin_owner", 32'({owner, cs_n_pin}), 32'h3);
        check("async_rst_busy_err", 32'({rq_busy, timeout_err}), 32'h6);
        @(negedge clk);
        rq_cs_n = 2'b00;
        @(negedge clk);
        fpga_rst_n = 1'b1;
        wait_grant(5);
        check("post_rst_tie", 32'(owner), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
